// File: rtl/waveform_analyzer_pkg.sv
// Shared types and constants for the waveform analyzer: wave classes, FSM
// states and the sample rail values used to spot square-wave plateaus.
package waveform_analyzer_pkg;

    typedef enum logic [1:0] {
        WAVE_NONE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_UNKNOWN  = 2'd3
    } wave_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_SEEK    = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    localparam logic [3:0] RAIL_LOW  = 4'b0000;
    localparam logic [3:0] RAIL_HIGH = 4'b1111;

    // A cycle that never left the rails is square; one that did, but only in
    // unit steps, is triangular; anything else is unclassifiable.
    function automatic wave_type_e classify(input logic nonrail, input logic big_step);
        wave_type_e c;
        c = WAVE_UNKNOWN;
        if (!nonrail) begin
            c = WAVE_SQUARE;
        end else if (!big_step) begin
            c = WAVE_TRIANGLE;
        end
        return c;
    endfunction

endpackage

// File: rtl/waveform_slope_detector.sv
// Tracks the previous accepted sample and its slope direction; flags cycle
// boundaries (falling/flat -> rising transitions) and per-sample shape hints.
module waveform_slope_detector
    import waveform_analyzer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [3:0] sample,
    output logic       have_prev,
    output logic       boundary,
    output logic       nonrail,
    output logic       big_step
);

    logic [3:0]        prev_sample;
    logic              prev_rising;
    logic signed [4:0] delta;
    logic              rising;

    // Slope is only meaningful once a previous sample is held.
    always_comb begin
        delta    = $signed({1'b0, sample}) - $signed({1'b0, prev_sample});
        rising   = have_prev && (delta > 5'sd0);
        boundary = rising && !prev_rising;
        nonrail  = (sample != RAIL_LOW) && (sample != RAIL_HIGH);
        big_step = have_prev && ((delta > 5'sd1) || (delta < -5'sd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sample <= 4'd0;
            prev_rising <= 1'b1;
            have_prev   <= 1'b0;
        end else if (accept) begin
            prev_sample <= sample;
            have_prev   <= 1'b1;
            if (have_prev) begin
                prev_rising <= rising;
            end
        end
    end

endmodule

// File: rtl/waveform_analyzer.sv
// Measures period and shape of a 4-bit periodic sample stream, asserting
// lock after repeated identical cycle results and flagging lost signals.
module waveform_analyzer
    import waveform_analyzer_pkg::*;
#(
    parameter int PERIOD_W    = 8,
    parameter int MAX_PERIOD  = 255,
    parameter int LOCK_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [3:0]          sample,
    output logic                result_valid,
    output logic [1:0]          wave_type,
    output logic [PERIOD_W-1:0] period,
    output logic                locked,
    output logic                timeout
);

    localparam int                  MATCH_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [PERIOD_W-1:0] MAX_CNT   = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] SEEK_LAST = PERIOD_W'(MAX_PERIOD - 1);
    localparam logic [MATCH_W-1:0]  LOCK_N    = MATCH_W'(LOCK_CYCLES);

    state_e               state, state_next;
    logic [PERIOD_W-1:0]  cnt, cnt_next;
    logic                 nonrail_acc, nonrail_acc_next;
    logic                 big_step_acc, big_step_acc_next;
    logic [MATCH_W-1:0]   match_cnt, match_next;
    logic                 have_prev, boundary, nonrail, big_step;
    logic                 slope_ok, close_cycle, timeout_hit, same_result;
    wave_type_e           cycle_class;

    waveform_slope_detector u_slope (
        .clk       (clk),
        .rst       (rst),
        .accept    (sample_valid),
        .sample    (sample),
        .have_prev (have_prev),
        .boundary  (boundary),
        .nonrail   (nonrail),
        .big_step  (big_step)
    );

    // SEEK counts from entry (cnt 0), MEASURE from the boundary sample (cnt 1),
    // so both time out after MAX_PERIOD samples without a boundary.
    assign slope_ok    = sample_valid && have_prev;
    assign close_cycle = slope_ok && boundary && (state == ST_MEASURE);
    assign timeout_hit = slope_ok && !boundary &&
                         (((state == ST_SEEK) && (cnt == SEEK_LAST)) ||
                          ((state == ST_MEASURE) && (cnt == MAX_CNT)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY:   if (sample_valid) state_next = ST_SEEK;
            ST_SEEK:    if (slope_ok && boundary) state_next = ST_MEASURE;
            ST_MEASURE: if (timeout_hit) state_next = ST_SEEK;
            default:    state_next = ST_EMPTY;
        endcase
    end

    // A boundary sample closes the old cycle and seeds the flags of the new one.
    always_comb begin
        cnt_next          = cnt;
        nonrail_acc_next  = nonrail_acc;
        big_step_acc_next = big_step_acc;
        if (sample_valid) begin
            if (boundary) begin
                nonrail_acc_next  = nonrail;
                big_step_acc_next = big_step;
            end else begin
                nonrail_acc_next  = nonrail_acc || nonrail;
                big_step_acc_next = big_step_acc || big_step;
            end
        end
        if (slope_ok && (state != ST_EMPTY)) begin
            if (boundary) begin
                cnt_next = PERIOD_W'(1);
            end else if (timeout_hit) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt + PERIOD_W'(1);
            end
        end

        cycle_class = classify(nonrail_acc, big_step_acc);
        same_result = (match_cnt != '0) && (wave_type == cycle_class) && (period == cnt);
        if (!same_result) begin
            match_next = MATCH_W'(1);
        end else if (match_cnt >= LOCK_N) begin
            match_next = match_cnt;
        end else begin
            match_next = match_cnt + MATCH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            nonrail_acc  <= 1'b0;
            big_step_acc <= 1'b0;
            match_cnt    <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            wave_type    <= WAVE_NONE;
            period       <= '0;
            locked       <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            nonrail_acc  <= nonrail_acc_next;
            big_step_acc <= big_step_acc_next;
            result_valid <= close_cycle;
            timeout      <= timeout_hit;
            if (close_cycle) begin
                wave_type <= cycle_class;
                period    <= cnt;
                match_cnt <= match_next;
                locked    <= (match_next >= LOCK_N);
            end else if (timeout_hit) begin
                wave_type <= WAVE_NONE;
                period    <= '0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/waveform_analyzer.md
Name: waveform_analyzer

Overview:
Receive-side companion to the square/triangle waveform generators. Consumes a 4-bit sample stream and finds cycle boundaries. For each complete cycle it measures the period, classifies the wave as square, triangle or unknown, and asserts lock once the results are stable. It sits downstream of any generator output, behind an optional valid qualifier, as a self-check/monitor block.

Parameters:
PERIOD_W, 8, width of the period counter and the period output
MAX_PERIOD, 255, largest measurable period in accepted samples; must be at most 2^PERIOD_W-1
LOCK_CYCLES, 3, number of consecutive identical cycle results needed to assert locked; must be at least 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
sample_valid  in  1  qualifies sample; only accepted samples (valid=1 at a clk edge) count
sample  in  4  unsigned waveform sample
result_valid  out  1  one-cycle pulse when a cycle result is registered
wave_type  out  2  0=NONE, 1=SQUARE, 2=TRIANGLE, 3=UNKNOWN; holds the last result
period  out  PERIOD_W  accepted samples per cycle; holds the last result
locked  out  1  LOCK_CYCLES consecutive identical (wave_type, period) results seen
timeout  out  1  one-cycle pulse when no boundary is seen within MAX_PERIOD samples

Behaviour:
- Reset values: result_valid=0, wave_type=NONE, period=0, locked=0, timeout=0. Also state=EMPTY, prev_rising=1, cnt=0, match_cnt=0, cycle flags clear.
- All outputs are registered. A result appears on the cycle after the boundary sample is accepted.
- delta = sample - prev_sample, computed signed at 5 bits. Defined only when a previous sample is held.
- rising = (delta > 0). boundary = rising AND NOT prev_rising. prev_rising updates on every accepted sample that has a delta.
- Cycle flags, accumulated over accepted samples:
  - nonrail: the sample is neither 0000 nor 1111.
  - big_step: |delta| > 1.
- At a boundary, the flags are cleared first; the boundary sample's own flags then start the new cycle.
- Classification of a closed cycle:
  - !nonrail gives SQUARE.
  - nonrail && !big_step gives TRIANGLE.
  - Anything else gives UNKNOWN.
- States:
  - EMPTY: no prev sample held. The first accepted sample is stored and the block moves to SEEK; no delta is computed.
  - SEEK: waiting for the first boundary. On a boundary: cnt=1, clear flags, move to MEASURE. No result is produced in SEEK.
  - MEASURE: each accepted non-boundary sample does cnt+1. On a boundary: period<=cnt, wave_type<=class, result_valid pulses, cnt=1, flags cleared, stay in MEASURE.
- Timeout: in SEEK or MEASURE, once MAX_PERIOD accepted samples have passed since the last boundary (or since entering SEEK) without a new boundary:
  - timeout pulses, locked=0, match_cnt=0, wave_type=NONE, period=0.
  - The block moves to SEEK; the prev sample is kept and cnt is cleared.
  - result_valid is not pulsed.
- Lock:
  - On each result, if it equals the previous result (type and period): match_cnt+1, saturating at LOCK_CYCLES.
  - Otherwise match_cnt=1.
  - locked = (match_cnt >= LOCK_CYCLES) and updates in the same cycle as result_valid.
  - A mismatching result drops locked in that same cycle.
- sample_valid=0 freezes all state; pulse outputs deassert.
- Reset asserted mid-operation returns everything to reset values immediately, asynchronously. The first sample after release is treated as EMPTY.

Decomposition:
- Shared package: wave_type codes (NONE/SQUARE/TRIANGLE/UNKNOWN), the analyzer state enum (EMPTY/SEEK/MEASURE), and the 4-bit rail constants 0000/1111.
- Sub-module waveform_slope_detector holds prev_sample and prev_rising. It outputs have_prev, boundary, nonrail and big_step per accepted sample.
- The FSM, period counter and lock logic stay in the top level.

Test Plan:
1. Square generator output, reset at t0, valid always 1 (stream 8x0000 then 8x1111, repeating) -> first boundary at sample 8; result_valid one cycle after sample 24 with SQUARE, period=16; locked=1 with the third result (after sample 56).
2. Triangle generator output (0..7,7..0 repeating) -> boundaries at samples 17, 33, ...; TRIANGLE, period=16; locked from the third result (after sample 65).
3. Square stream with sample_valid deasserted for 1 of every 3 cycles -> period is still 16 and lock still achieved; wall-clock spacing between results is 24 cycles.
4. Constant 0101 input, MAX_PERIOD=255 -> no result_valid; timeout pulses once 255 samples after entering SEEK and repeats every 255 samples; wave_type=NONE, locked=0.
5. Locked on square, switch the stream to triangle mid-run -> the first mismatching result (UNKNOWN or TRIANGLE) clears locked in the same cycle; locked returns after 3 matching TRIANGLE results.
6. Reset pulse while locked, then square resumes -> all outputs read their reset values during rst; after release the sequence of test 1 repeats, with the first result 24 samples after release (stream phase-aligned to start).
